pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control, branch-target table,
// redirect pulse and a saturating count of RUN cycles.
module pc_sequencer #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32
) (
    input  logic            Clk,
    input  logic            reset,
    input  logic            Start,
    input  logic            Halt,
    input  logic            Stall,
    input  logic            branch,
    input  logic [4:0]      Br_idx,
    input  logic            Lut_we,
    input  logic [4:0]      Lut_addr,
    input  logic [PC_W-1:0] Lut_data,
    output logic [PC_W-1:0] Prog_ctr,
    output logic            Running,
    output logic            Done,
    output logic            Taken,
    output logic [15:0]     Cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              taken_q, taken_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [PC_W-1:0]   lut_q [LUT_DEPTH];

    // Table survives reset; a same-edge write is seen by branches only from the next edge.
    always_ff @(posedge Clk) begin
        if (Lut_we) begin
            lut_q[Lut_addr] <= Lut_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        taken_d = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (Start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (Halt) begin
                    state_d = DONE;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (branch) begin
                    pc_d    = lut_q[Br_idx];
                    taken_d = 1'b1;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Prog_ctr  = pc_q;
    assign Running   = (state_q == RUN);
    assign Done      = (state_q == DONE);
    assign Taken     = taken_q;
    assign Cycle_cnt = cnt_q;

endmodule
